add_result_accumulator: RTL
===========================

ADD_RESULT_ACCUMULATOR -- requirements
Module: add_result_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the upstream adder operand width; each input sample is WIDTH+1 bits (sum plus carry-out).
REQ-002 The block SHALL have parameter ACC_WIDTH, default 16, giving the accumulator width; ACC_WIDTH SHALL be >= WIDTH+1.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low. It SHALL expose port i_clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL expose port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL expose port i_result, input, WIDTH+1 bits: the adder result sample, treated as unsigned.
REQ-006 The block SHALL expose port i_valid, input, 1 bit: i_result and i_last are valid this cycle.
REQ-007 The block SHALL expose port i_last, input, 1 bit: this sample is the final beat of a packet.
REQ-008 The block SHALL expose port o_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-009 The block SHALL expose port o_sum, output, ACC_WIDTH bits: the running or final accumulated sum.
REQ-010 The block SHALL expose port o_count, output, 16 bits: the number of samples accepted in the current packet.
REQ-011 The block SHALL expose port o_overflow, output, 1 bit: sticky flag, set when the accumulator wrapped during the current packet.
REQ-012 The block SHALL expose port o_valid, output, 1 bit: a packet result is presented on o_sum, o_count and o_overflow.
REQ-013 The block SHALL expose port i_ready, input, 1 bit: the downstream stage accepts the presented result.

Function
REQ-014 A sample SHALL be accepted on a rising edge where i_valid=1 and o_ready=1; no other condition accepts a sample.
REQ-015 The FSM SHALL have states IDLE, ACCUM and HOLD; o_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; o_valid SHALL be 1 only in HOLD.
REQ-016 On an accept in IDLE, the block SHALL load the zero-extended i_result into o_sum, set o_count=1 and o_overflow=0, then go to HOLD if i_last=1, else to ACCUM.
REQ-017 On an accept in ACCUM, o_sum SHALL become (o_sum + zero-extended i_result) mod 2^ACC_WIDTH, and o_count SHALL increment.
REQ-018 o_count SHALL saturate at 16'hFFFF.
REQ-019 o_overflow SHALL be set if that addition produces a carry out of bit ACC_WIDTH-1, and SHALL then stay set until the next IDLE accept.
REQ-020 On an accept in ACCUM with i_last=1, the block SHALL go to HOLD.
REQ-021 o_valid SHALL rise on the cycle after the i_last accept, giving a fixed 1-cycle latency.
REQ-022 In HOLD, o_sum, o_count and o_overflow SHALL remain stable while i_ready=0, for any number of cycles.
REQ-023 In HOLD with i_ready=1, the block SHALL return to IDLE on the next edge, and o_valid SHALL fall that edge.
REQ-024 A sample offered in the same cycle as the HOLD handshake SHALL NOT be accepted, because o_ready=0.
REQ-025 In IDLE, o_sum, o_count and o_overflow SHALL retain the last packet's values until the next accept.
REQ-026 All outputs SHALL be registered, with no combinational path from i_valid, i_last or i_result to any output.
REQ-027 o_ready SHALL be a pure function of the FSM state.
REQ-028 A cycle with i_valid=0 in ACCUM SHALL change no state.

Reset
REQ-029 While i_rst_n=0, the block SHALL asynchronously and immediately force state IDLE, o_sum=0, o_count=0, o_overflow=0 and o_valid=0.
REQ-030 Reset SHALL take effect from any state, including mid-packet in ACCUM and while waiting in HOLD; any partial packet SHALL be discarded.
REQ-031 After i_rst_n deasserts, o_ready SHALL be 1 and a sample SHALL be accepted on the first rising edge with i_valid=1.

Verification (WIDTH=8, ACC_WIDTH=16)
REQ-032 Single beat: i_result=9'h1FE with i_last=1 -> next cycle o_valid=1, o_sum=16'h01FE, o_count=1, o_overflow=0.
REQ-033 Three beats 9'h100, 9'h0FF, 9'h001, with i_last on the third -> o_sum=16'h0200, o_count=3, o_overflow=0.
REQ-034 129 beats of 9'h1FF, with i_last on the last -> o_sum=16'h017F, o_count=129, o_overflow=1.
REQ-035 HOLD with i_ready=0 for 5 cycles while i_valid=1 -> o_ready=0 and outputs unchanged throughout; with i_ready=1 -> IDLE next cycle, and the pending beat is accepted the following edge as count 1.
REQ-036 Async reset after 2 beats in ACCUM -> all outputs 0 before the next clock edge; a subsequent single beat 9'h005 with i_last -> o_sum=16'h0005, o_count=1.
REQ-037 Gapped input: i_valid toggles 1/0 across 4 beats of 9'h010 -> o_sum=16'h0040 and o_count=4, with idle cycles causing no change.

Source files
------------

// File: rtl/add_result_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add_result_accumulator: sums adder result samples per packet and holds   |
// | the total until the downstream stage takes it.                    Rev 1.0 |
// +--------------------------------------------------------------------------+
module add_result_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH:0]       i_result,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic [15:0]          o_count,
  output logic                 o_overflow,
  output logic                 o_valid,
  input  logic                 i_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [15:0]          count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic                 w_ready;
  logic                 w_accept;
  logic [ACC_WIDTH-1:0] w_result_ext;
  logic [ACC_WIDTH:0]   w_add_full;

  // Ready depends on state alone so no input can reach an output combinationally.
  assign w_ready      = (state_q != S_HOLD);
  assign w_accept     = i_valid && w_ready;
  assign w_result_ext = ACC_WIDTH'(i_result);
  assign w_add_full   = {1'b0, sum_q} + {1'b0, w_result_ext};

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          sum_d      = w_result_ext;
          count_d    = 16'd1;
          overflow_d = 1'b0;
          state_d    = i_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          sum_d      = w_add_full[ACC_WIDTH-1:0];
          count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          overflow_d = overflow_q | w_add_full[ACC_WIDTH];
          if (i_last) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_ready    = w_ready;
  assign o_valid    = (state_q == S_HOLD);
  assign o_sum      = sum_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule
`default_nettype wire
